clock_enable_gen: RTL and testbench

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

---
 rtl/clock_enable_gen.sv | 55 +++++
 tb/tb_clock_enable_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: per-channel programmable 50%-duty clock dividers with glitch-free divisor update
module clock_enable_gen #(
   parameter int N_CH = 4,
   parameter int DIV_W = 8,
   parameter int DEF_DIV_SHIFT = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             restart,
   output logic [N_CH-1:0]  div_clk,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pend,
   output logic [DIV_W-1:0] rd_div
);
   logic [DIV_W-1:0] act [N_CH];
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam logic [DIV_W-1:0] DEF = DIV_W'(1) << (c + DEF_DIV_SHIFT);
      logic [DIV_W-1:0] d, s, cnt, d_nx;
      logic q, tk, pd, sel, term, q_nx;
      assign sel  = cfg_we && cfg_ch == 4'(c);
      assign term = d != '0 && cnt == d - DIV_W'(1);
      // divisor only changes at a terminal edge, while stopped, or on restart
      assign d_nx = restart ? (sel ? cfg_div : pd ? s : d)
                  : (sel && (d == '0 || term)) ? cfg_div
                  : (term && pd) ? s : d;
      assign q_nx = (restart || d == '0) ? 1'b0 : term ? (d_nx != '0 && !q) : q;
      always_ff @(posedge clock)
         if (reset) begin
            d   <= DEF;
            s   <= DEF;
            cnt <= '0;
            q   <= 1'b0;
            tk  <= 1'b0;
            pd  <= 1'b0;
         end else begin
            d   <= d_nx;
            s   <= sel ? cfg_div : s;
            cnt <= (restart || d == '0 || term) ? '0 : cnt + DIV_W'(1);
            q   <= q_nx;
            tk  <= q_nx && !q;
            pd  <= restart ? 1'b0 : sel ? (d != '0 && !term) : (pd && !term);
         end
      assign act[c]     = d;
      assign div_clk[c] = q;
      assign tick[c]    = tk;
      assign pend[c]    = pd;
   end
   always_comb begin
      rd_div = '0;
      for (int k = 0; k < N_CH; k++) rd_div = (cfg_ch == 4'(k)) ? act[k] : rd_div;
   end
endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: scoreboard bench for clock_enable_gen with a cycle model plus directed checks
module tb_clock_enable_gen;
   localparam int N_CH = 4;
   localparam int DIV_W = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_we = 1'b0;
   logic [3:0]       cfg_ch = 4'd0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic             restart = 1'b0;
   logic [N_CH-1:0]  div_clk, tick, pend;
   logic [DIV_W-1:0] rd_div;

   typedef struct {
      logic [N_CH-1:0]  clk;
      logic [N_CH-1:0]  tk;
      logic [N_CH-1:0]  pd;
      logic [DIV_W-1:0] rd;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;

   int md [N_CH];
   int ms [N_CH];
   int mc [N_CH];
   bit mq [N_CH];
   bit mp [N_CH];
   bit mt [N_CH];

   always #5 clock = ~clock;

   clock_enable_gen #(.N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV_SHIFT(0)) dut (
      .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .restart(restart), .div_clk(div_clk), .tick(tick), .pend(pend), .rd_div(rd_div)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step(input bit r, input bit rs, input bit we, input int ch, input int dv);
      exp_t x;
      bit   hit, term, q0;
      @(negedge clock);
      reset = r;
      restart = rs;
      cfg_we = we;
      cfg_ch = 4'(ch);
      cfg_div = 8'(dv);
      for (int i = 0; i < N_CH; i++) begin
         hit = we && ch == i;
         term = md[i] != 0 && mc[i] == md[i] - 1;
         q0 = mq[i];
         if (r) begin
            md[i] = 1 << i;
            ms[i] = 1 << i;
            mc[i] = 0;
            mq[i] = 0;
            mp[i] = 0;
         end else if (rs) begin
            if (hit) md[i] = dv;
            else if (mp[i]) md[i] = ms[i];
            if (hit) ms[i] = dv;
            mc[i] = 0;
            mq[i] = 0;
            mp[i] = 0;
         end else if (md[i] == 0) begin
            if (hit) begin
               md[i] = dv;
               ms[i] = dv;
            end
            mc[i] = 0;
            mq[i] = 0;
         end else if (term) begin
            if (hit) begin
               md[i] = dv;
               ms[i] = dv;
            end else if (mp[i]) md[i] = ms[i];
            mp[i] = 0;
            mc[i] = 0;
            mq[i] = (md[i] == 0) ? 1'b0 : !q0;
         end else begin
            mc[i]++;
            if (hit) begin
               ms[i] = dv;
               mp[i] = 1;
            end
         end
         mt[i] = mq[i] && !q0;
         x.clk[i] = mq[i];
         x.tk[i] = mt[i];
         x.pd[i] = mp[i];
      end
      x.rd = (ch < N_CH) ? 8'(md[ch]) : '0;
      sb.push_back(x);
   endtask

   task automatic idle(input int n, input int ch);
      for (int k = 0; k < n; k++) step(0, 0, 0, ch, 0);
   endtask

   task automatic after_edge();
      @(posedge clock);
      #2;
   endtask

   always @(posedge clock) begin
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("div_clk", div_clk, e.clk);
         chk("tick", tick, e.tk);
         chk("pend", pend, e.pd);
         chk("rd_div", rd_div, e.rd);
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 2, 0);
      after_edge();
      chk("rst_div_clk", div_clk, 0);
      chk("rst_pend", pend, 0);
      chk("rst_rd_div2", rd_div, 4);
      for (int t = 1; t <= 32; t++) begin
         step(0, 0, 0, 1, 0);
         after_edge();
         for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("period_clk%0d", i), div_clk[i], ((t >> i) & 1));
            chk($sformatf("period_tick%0d", i), tick[i], (t % (2 << i)) == (1 << i));
         end
      end
      step(0, 0, 1, 1, 3);
      after_edge();
      chk("pend1_set", pend[1], 1);
      chk("rd_div1_old", rd_div, 2);
      step(0, 0, 1, 0, 0);
      after_edge();
      chk("ch0_off_clk", div_clk[0], 0);
      chk("ch0_off_rd", rd_div, 0);
      idle(14, 0);
      after_edge();
      chk("ch0_stays_off", div_clk[0], 0);
      step(0, 0, 1, 0, 5);
      after_edge();
      chk("ch0_rd5", rd_div, 5);
      chk("ch0_pend_none", pend[0], 0);
      idle(25, 1);
      step(0, 1, 0, 2, 0);
      after_edge();
      chk("restart_clk", div_clk, 0);
      chk("restart_tick", tick, 0);
      idle(20, 3);
      step(0, 0, 1, 7, 9);
      after_edge();
      chk("bad_ch_pend", pend, 0);
      chk("bad_ch_rd", rd_div, 0);
      idle(5, 7);
      step(0, 1, 1, 2, 3);
      after_edge();
      chk("restart_we_rd", rd_div, 3);
      chk("restart_we_pend", pend, 0);
      idle(3, 3);
      step(0, 0, 1, 3, 2);
      step(0, 0, 1, 3, 6);
      idle(40, 3);
      step(0, 0, 1, 0, 255);
      idle(12, 0);
      step(0, 0, 1, 2, 7);
      idle(2, 2);
      step(1, 0, 0, 2, 0);
      after_edge();
      chk("rst_lost_pend", pend, 0);
      chk("rst_lost_rd", rd_div, 4);
      step(0, 0, 0, 2, 0);
      idle(20, 1);
      repeat (2) @(posedge clock);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
